// File: rtl/data_mem_pkg.sv
// Shared defaults and types for the RV32 data memory.
// Imported by data_memory and data_mem_lane_merge.
package data_mem_pkg;

    localparam int ADDR_W_DEF = 6;
    localparam int DATA_W_DEF = 32;
    localparam int LANES_DEF  = DATA_W_DEF / 8;

    typedef logic [DATA_W_DEF-1:0] word_t;

endpackage

// File: rtl/data_mem_lane_merge.sv
// Combinational byte-lane merge: each lane takes the new byte when its enable
// is set, otherwise it keeps the byte already stored in the word.
module data_mem_lane_merge
    import data_mem_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [DATA_W-1:0]   oldWord_i,
    input  logic [DATA_W-1:0]   newWord_i,
    input  logic [DATA_W/8-1:0] laneEn_i,
    output logic [DATA_W-1:0]   merged_o
);

    for (genvar i = 0; i < DATA_W / 8; i++) begin : g_lane
        assign merged_o[8*i +: 8] = laneEn_i[i] ? newWord_i[8*i +: 8] : oldWord_i[8*i +: 8];
    end

endmodule

// File: rtl/data_memory.sv
// Word-addressed data memory: synchronous store, combinational load, clear-on-reset.
// Byte-lane writes are enabled by defining DATA_MEM_BYTE_WE_EN (adds the BE port).
module data_memory
    import data_mem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = 2 ** ADDR_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   A,
    input  logic [DATA_W-1:0]   WD,
    input  logic                WE,
`ifdef DATA_MEM_BYTE_WE_EN
    input  logic [DATA_W/8-1:0] BE,
`endif
    output logic [DATA_W-1:0]   RD
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              inRange;
    logic [DATA_W-1:0] curWord;
    logic [DATA_W-1:0] nextWord_d;

    // A full-depth memory has no out-of-range addresses to filter.
    if (DEPTH == (1 << ADDR_W)) begin : g_fullRange
        assign inRange = 1'b1;
    end else begin : g_partialRange
        assign inRange = (int'(A) < DEPTH);
    end

    always_comb begin
        curWord = '0;
        if (inRange) begin
            curWord = mem_q[A];
        end
    end

    assign RD = curWord;

`ifdef DATA_MEM_BYTE_WE_EN
    data_mem_lane_merge #(
        .DATA_W(DATA_W)
    ) u_laneMerge (
        .oldWord_i(curWord),
        .newWord_i(WD),
        .laneEn_i (BE),
        .merged_o (nextWord_d)
    );
`else
    assign nextWord_d = WD;
`endif

    // Reset clears every word and overrides any store issued in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (WE && inRange) begin
            mem_q[A] <= nextWord_d;
        end
    end

endmodule

// File: tb/tb_data_memory.sv
// Self-checking bench for data_memory against an array-based reference model.
// Define DATA_MEM_BYTE_WE_EN to exercise byte-lane writes.
module tb_data_memory;

    localparam int AW    = 6;
    localparam int DW    = 32;
    localparam int NW    = 64;
    localparam int LANES = DW / 8;

    logic          clk;
    logic          rst;
    logic [AW-1:0] A;
    logic [DW-1:0] WD;
    logic          WE;
`ifdef DATA_MEM_BYTE_WE_EN
    logic [LANES-1:0] BE;
`endif
    logic [DW-1:0] RD;

    data_mem_pkg::word_t model [NW];

    int checks = 0;
    int errors = 0;

    data_memory #(
        .ADDR_W(AW),
        .DATA_W(DW),
        .DEPTH (NW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .A  (A),
        .WD (WD),
        .WE (WE),
`ifdef DATA_MEM_BYTE_WE_EN
        .BE (BE),
`endif
        .RD (RD)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL timeout: simulation exceeded time limit");
        $fatal(1, "[TB] timeout");
    end

    // Advance one rising edge, then settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference store: full-word replace, or per-byte merge when lanes exist.
    task automatic modelWrite(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [LANES-1:0] lanes);
        for (int i = 0; i < LANES; i++) begin
            if (lanes[i]) model[a][8*i +: 8] = d[8*i +: 8];
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < NW; i++) model[i] = '0;
    endtask

    task automatic setInputs(input logic r, input logic [AW-1:0] a, input logic [DW-1:0] d,
                             input logic we, input logic [LANES-1:0] lanes);
        rst = r;
        A   = a;
        WD  = d;
        WE  = we;
`ifdef DATA_MEM_BYTE_WE_EN
        BE  = lanes;
`else
        if (lanes != '1) $display("[TB] note: lane mask ignored in full-word build");
`endif
        #1;
    endtask

    task automatic test_reset();
        logic [AW-1:0] addrs [3];
        addrs[0] = 6'd0;
        addrs[1] = 6'd17;
        addrs[2] = 6'd63;
        setInputs(1'b1, 6'd0, 32'h0, 1'b0, '1);
        tick();
        modelReset();
        for (int i = 0; i < 3; i++) begin
            setInputs(1'b0, addrs[i], 32'h0, 1'b0, '1);
            checks++;
            if (RD !== 32'h0) begin
                errors++;
                $display("[TB] FAIL reset_read A=%0d got=%h exp=%h", addrs[i], RD, 32'h0);
            end
        end
    endtask

    task automatic test_write_read();
        setInputs(1'b0, 6'd0, 32'd15, 1'b1, '1);
        tick();
        modelWrite(6'd0, 32'd15, '1);
        WE = 1'b0;
        #1;
        checks++;
        if (RD !== 32'd15) begin
            errors++;
            $display("[TB] FAIL write_read A=0 got=%h exp=%h", RD, 32'd15);
        end
    endtask

    task automatic test_second_write();
        setInputs(1'b0, 6'd30, 32'd60, 1'b1, '1);
        tick();
        modelWrite(6'd30, 32'd60, '1);
        setInputs(1'b0, 6'd30, 32'd0, 1'b0, '1);
        checks++;
        if (RD !== 32'd60) begin
            errors++;
            $display("[TB] FAIL second_write A=30 got=%h exp=%h", RD, 32'd60);
        end
        setInputs(1'b0, 6'd0, 32'd0, 1'b0, '1);
        checks++;
        if (RD !== 32'd15) begin
            errors++;
            $display("[TB] FAIL addr0_undisturbed got=%h exp=%h", RD, 32'd15);
        end
    endtask

    task automatic test_read_during_write();
        setInputs(1'b0, 6'd5, 32'd7, 1'b1, '1);
        tick();
        modelWrite(6'd5, 32'd7, '1);
        setInputs(1'b0, 6'd5, 32'd9, 1'b1, '1);
        checks++;
        if (RD !== 32'd7) begin
            errors++;
            $display("[TB] FAIL rdw_before_edge got=%h exp=%h", RD, 32'd7);
        end
        tick();
        modelWrite(6'd5, 32'd9, '1);
        WE = 1'b0;
        #1;
        checks++;
        if (RD !== 32'd9) begin
            errors++;
            $display("[TB] FAIL rdw_after_edge got=%h exp=%h", RD, 32'd9);
        end
    endtask

    task automatic test_reset_priority();
        setInputs(1'b0, 6'd2, 32'h1234_5678, 1'b1, '1);
        tick();
        modelWrite(6'd2, 32'h1234_5678, '1);
        setInputs(1'b1, 6'd2, 32'hDEAD_BEEF, 1'b1, '1);
        tick();
        modelReset();
        setInputs(1'b0, 6'd2, 32'h0, 1'b0, '1);
        checks++;
        if (RD !== 32'h0) begin
            errors++;
            $display("[TB] FAIL reset_priority A=2 got=%h exp=%h", RD, 32'h0);
        end
        setInputs(1'b0, 6'd5, 32'h0, 1'b0, '1);
        checks++;
        if (RD !== 32'h0) begin
            errors++;
            $display("[TB] FAIL reset_clears_other A=5 got=%h exp=%h", RD, 32'h0);
        end
    endtask

`ifdef DATA_MEM_BYTE_WE_EN
    task automatic test_byte_lanes();
        setInputs(1'b0, 6'd4, 32'h1122_3344, 1'b1, 4'b1111);
        tick();
        modelWrite(6'd4, 32'h1122_3344, 4'b1111);
        setInputs(1'b0, 6'd4, 32'hAABB_CCDD, 1'b1, 4'b0101);
        tick();
        modelWrite(6'd4, 32'hAABB_CCDD, 4'b0101);
        WE = 1'b0;
        #1;
        checks++;
        if (RD !== 32'h11BB_33DD) begin
            errors++;
            $display("[TB] FAIL byte_lanes_0101 got=%h exp=%h", RD, 32'h11BB_33DD);
        end
        setInputs(1'b0, 6'd4, 32'hFFFF_FFFF, 1'b1, 4'b0000);
        tick();
        WE = 1'b0;
        #1;
        checks++;
        if (RD !== 32'h11BB_33DD) begin
            errors++;
            $display("[TB] FAIL byte_lanes_none got=%h exp=%h", RD, 32'h11BB_33DD);
        end
    endtask
`endif

    task automatic test_back_to_back();
        logic [DW-1:0] d;
        for (int i = 0; i < 8; i++) begin
            d = $urandom;
            setInputs(1'b0, AW'(40 + i), d, 1'b1, '1);
            tick();
            modelWrite(AW'(40 + i), d, '1);
        end
        WE = 1'b0;
        for (int i = 0; i < 8; i++) begin
            A = AW'(40 + i);
            #1;
            checks++;
            if (RD !== model[40 + i]) begin
                errors++;
                $display("[TB] FAIL back_to_back A=%0d got=%h exp=%h", 40 + i, RD, model[40 + i]);
            end
        end
    endtask

    task automatic test_random();
        logic [AW-1:0]    a;
        logic [DW-1:0]    d;
        logic             we;
        logic             r;
        logic [LANES-1:0] lanes;
        for (int n = 0; n < 300; n++) begin
            a  = AW'($urandom_range(0, NW - 1));
            d  = $urandom;
            we = ($urandom_range(0, 3) != 0);
            r  = ($urandom_range(0, 59) == 0);
`ifdef DATA_MEM_BYTE_WE_EN
            lanes = LANES'($urandom);
`else
            lanes = '1;
`endif
            setInputs(r, a, d, we, lanes);
            checks++;
            if (RD !== model[a]) begin
                errors++;
                $display("[TB] FAIL random_pre_edge n=%0d A=%0d got=%h exp=%h", n, a, RD, model[a]);
            end
            tick();
            if (r) modelReset();
            else if (we) modelWrite(a, d, lanes);
            rst = 1'b0;
            WE  = 1'b0;
            A   = AW'($urandom_range(0, NW - 1));
            #1;
            checks++;
            if (RD !== model[A]) begin
                errors++;
                $display("[TB] FAIL random_post_edge n=%0d A=%0d got=%h exp=%h", n, A, RD, model[A]);
            end
        end
    endtask

    initial begin
        rst = 1'b0;
        A   = '0;
        WD  = '0;
        WE  = 1'b0;
`ifdef DATA_MEM_BYTE_WE_EN
        BE  = '1;
`endif
        #1;
        test_reset();
        test_write_read();
        test_second_write();
        test_read_during_write();
        test_reset_priority();
`ifdef DATA_MEM_BYTE_WE_EN
        test_byte_lanes();
`endif
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_memory.md
# data_memory

Word-organised read/write data memory for the single-cycle RV32 datapath. It sits behind the ALU address path and serves load/store instructions. Stores are committed on the rising clock edge. Loads are combinational, so a load completes within the same cycle it is issued.

## Interface

Parameters:
- ADDR_W, default 6: word-address width.
- DATA_W, default 32: word width in bits. Must be a multiple of 8.
- DEPTH, default 2**ADDR_W: number of words, fixed at 64 by default.

Ports:
- clk, input, 1: the only clock; all state changes on its rising edge.
- rst, input, 1: reset, synchronous and active-high.
- A, input, ADDR_W: word address. It indexes words, not bytes.
- WD, input, DATA_W: write data.
- WE, input, 1: write enable, active-high.
- BE, input, DATA_W/8: byte-lane enables. Present only when DATA_MEM_BYTE_WE_EN is defined.
- RD, output, DATA_W: read data.

## Operation

- Storage is an array of DEPTH words of DATA_W bits.
- Write: on a rising clk edge with rst=0 and WE=1, mem[A] is updated from WD.
- Read: RD = mem[A], purely combinational. RD follows A and the memory contents with no clock involvement.
- Reset: on a rising edge with rst=1, every word is set to 0.
  - Reset has priority over WE; a write in a reset cycle is dropped.
  - There is no reset-value register for RD. RD reads 0 from any address after the reset edge.
- WE=0: the memory holds its contents; RD still tracks A.
- Address range: every value of A is valid when DEPTH = 2**ADDR_W. If DEPTH is set smaller, an address ≥ DEPTH reads 0 and writes to it are ignored.
- Uninitialised contents before the first reset are X; no power-up value is guaranteed.

## Timing

- Write latency is one edge. New data is visible on RD just after the capturing rising edge, once A still selects that word.
- Read latency is zero cycles: combinational from A to RD.
- Read-during-write to the same address: before the edge RD shows the old word; after the edge it shows the new word. There is no write-through bypass.
- Reset mid-operation: the reset edge takes effect immediately and clears all words, including any word being written in that cycle.
- Back-to-back writes to different addresses on consecutive edges are all committed.

## Configuration

- DATA_MEM_BYTE_WE_EN defined:
  - BE port exists.
  - On a write, byte lane i (bits 8i+7:8i) is updated only when BE[i]=1; other lanes keep their old value.
  - WE=1 with BE=0 changes nothing.
- DATA_MEM_BYTE_WE_EN undefined:
  - There is no BE port.
  - Every write replaces the full word.

## Structure

- Shared package data_mem_pkg holds:
  - ADDR_W and DATA_W defaults.
  - The derived byte-lane count, DATA_W/8.
  - The word type, logic [DATA_W-1:0].
- One sub-module, data_mem_lane_merge, is natural. It is combinational and merges old word, WD and BE into the next word. It is instantiated only under DATA_MEM_BYTE_WE_EN.

## Test plan

- Reset: rst=1 for one edge, then A=0, 17 and 63 with WE=0 → RD=0 for each.
- Write then read: A=0, WD=15, WE=1, one edge → RD=15 within the same cycle the edge completes.
- Second write: A=30, WD=60, one edge → RD=60. Then A=0 → RD still 15, so address 0 was not disturbed.
- Read-during-write: A=5 holds 7; drive WD=9, WE=1 → RD=7 before the edge and RD=9 after it.
- Reset priority: rst=1, WE=1, A=2, WD=0xDEADBEEF on the same edge → RD at A=2 is 0.
- With DATA_MEM_BYTE_WE_EN, byte lanes: word A=4 holds 0x11223344; write WD=0xAABBCCDD with BE=4'b0101 → RD=0x11BB33DD.
